// File: rtl/uart_rx_os16_pkg.sv
// Shared definitions for the 16x-oversampling UART receiver: state encoding,
// oversample phase constants and the 3-sample majority vote.
package uart_rx_os16_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_e;

  localparam int unsigned OS_RATE       = 16;
  localparam int unsigned OS_W          = $clog2(OS_RATE);
  localparam logic [3:0]  SAMPLE_FIRST  = 4'd7;
  localparam logic [3:0]  SAMPLE_DECIDE = 4'd9;
  localparam logic [3:0]  OS_LAST       = 4'd15;
  localparam logic [2:0]  BIT_LAST      = 3'd7;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_os_tick.sv
// Free-running oversample tick divider: one-clk tick every OS_DIV clocks.
// Shared between the UART receiver and transmitter.
module uart_os_tick #(
  parameter int unsigned OS_DIV = 325
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int unsigned CW = (OS_DIV > 1) ? $clog2(OS_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(OS_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign tick = (cnt_q == CNT_LAST);

endmodule

// File: rtl/uart_rx_os16.sv
// 8N1 UART receiver with 16x oversampling and 3-sample majority voting.
// Returns to IDLE mid stop bit so back-to-back frames need no idle gap.
module uart_rx_os16
  import uart_rx_os16_pkg::*;
#(
  parameter int unsigned OS_DIV = 325
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_status,
  output logic       frame_err,
  output logic       busy
);

  logic tick;

  uart_os_tick #(.OS_DIV(OS_DIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  logic rx_meta_q;
  logic rx_s_q;

  state_e         state_q,     state_d;
  logic           armed_q,     armed_d;
  logic [OS_W-1:0] os_cnt_q,   os_cnt_d;
  logic [2:0]     bit_cnt_q,   bit_cnt_d;
  logic [7:0]     shift_q,     shift_d;
  logic [1:0]     samp_q,      samp_d;
  logic [7:0]     rx_data_q,   rx_data_d;
  logic           rx_valid_q,  rx_valid_d;
  logic           rx_status_q, rx_status_d;
  logic           frame_err_q, frame_err_d;

  logic decide;
  logic bit_val;

  // Synchronizer flops reset high so a reset release never looks like a start edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  assign decide  = tick && (os_cnt_q == SAMPLE_DECIDE);
  assign bit_val = majority3(samp_q[1], samp_q[0], rx_s_q);

  // NOTE: every _d gets its hold value first so no path through the case
  // leaves a variable unassigned and infers a latch.
  always_comb begin
    state_d     = state_q;
    armed_d     = armed_q;
    os_cnt_d    = os_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    samp_d      = samp_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    rx_status_d = rx_status_q;
    frame_err_d = frame_err_q;

    if (tick && state_q != IDLE) begin
      os_cnt_d = os_cnt_q + 1'b1;
      if (os_cnt_q >= SAMPLE_FIRST && os_cnt_q < SAMPLE_DECIDE) begin
        samp_d = {samp_q[0], rx_s_q};
      end
    end

    unique case (state_q)
      IDLE: begin
        if (tick) begin
          if (rx_s_q) begin
            armed_d = 1'b1;
          end else if (armed_q) begin
            state_d  = START;
            os_cnt_d = '0;
          end
        end
      end
      START: begin
        if (decide) begin
          if (bit_val) state_d     = IDLE;
          else         rx_status_d = 1'b0;
        end
        if (tick && os_cnt_q == OS_LAST) begin
          state_d   = DATA;
          bit_cnt_d = '0;
        end
      end
      DATA: begin
        if (decide) shift_d = {bit_val, shift_q[7:1]};
        if (tick && os_cnt_q == OS_LAST) begin
          if (bit_cnt_q == BIT_LAST) state_d   = STOP;
          else                       bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      STOP: begin
        if (decide) begin
          state_d = IDLE;
          if (bit_val) begin
            rx_data_d   = shift_q;
            rx_valid_d  = 1'b1;
            rx_status_d = 1'b1;
            frame_err_d = 1'b0;
            armed_d     = 1'b1;
          end else begin
            frame_err_d = 1'b1;
            armed_d     = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      armed_q     <= 1'b0;
      os_cnt_q    <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      samp_q      <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      rx_status_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      armed_q     <= armed_d;
      os_cnt_q    <= os_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      samp_q      <= samp_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      rx_status_q <= rx_status_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign rx_status = rx_status_q;
  assign frame_err = frame_err_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_os16.sv
// Directed bench for uart_rx_os16 at OS_DIV=4 (one bit = 64 clk): a frame
// table plus hand sequences for false start, break, glitch, back-to-back, reset.
module tb_uart_rx_os16;

  localparam int OS_DIV  = 4;
  localparam int BIT_CLK = OS_DIV * 16;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_status;
  logic       frame_err;
  logic       busy;

  uart_rx_os16 #(.OS_DIV(OS_DIV)) dut (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_status (rx_status),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int valid_cnt = 0;

  always @(negedge clk) begin
    if (rx_valid) valid_cnt = valid_cnt + 1;
  end

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         exp_inc;
    logic [7:0] exp_data;
    logic       exp_status;
    logic       exp_ferr;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks = checks + 1;
    if (actual !== expected) begin
      errors = errors + 1;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic send_bit(input logic v);
    rx = v;
    repeat (BIT_CLK) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_b);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(stop_b);
  endtask

  task automatic idle_bits(input int n);
    rx = 1'b1;
    repeat (n * BIT_CLK) @(negedge clk);
  endtask

  int base;
  int busy_cycles;

  initial begin
    vecs[0] = '{8'hA5, 1'b1, 1, 8'hA5, 1'b1, 1'b0};
    vecs[1] = '{8'h3C, 1'b0, 0, 8'hA5, 1'b0, 1'b1};
    vecs[2] = '{8'h81, 1'b1, 1, 8'h81, 1'b1, 1'b0};
    vecs[3] = '{8'h00, 1'b1, 1, 8'h00, 1'b1, 1'b0};
    vecs[4] = '{8'hFF, 1'b1, 1, 8'hFF, 1'b1, 1'b0};
    vecs[5] = '{8'h3C, 1'b0, 0, 8'hFF, 1'b0, 1'b1};
    vecs[6] = '{8'h7E, 1'b1, 1, 8'h7E, 1'b1, 1'b0};

    // Reset state
    reset = 1'b0;
    rx    = 1'b1;
    repeat (4) @(negedge clk);
    check("reset rx_data",   rx_data,   8'h00);
    check("reset rx_valid",  rx_valid,  1'b0);
    check("reset rx_status", rx_status, 1'b0);
    check("reset frame_err", frame_err, 1'b0);
    check("reset busy",      busy,      1'b0);
    reset = 1'b1;
    idle_bits(2);

    // Frame table
    for (int v = 0; v < 7; v++) begin
      base = valid_cnt;
      send_frame(vecs[v].data, vecs[v].stop);
      idle_bits(2);
      check($sformatf("vec%0d valid pulses", v), valid_cnt - base, vecs[v].exp_inc);
      check($sformatf("vec%0d rx_data", v),      rx_data,          vecs[v].exp_data);
      check($sformatf("vec%0d rx_status", v),    rx_status,        vecs[v].exp_status);
      check($sformatf("vec%0d frame_err", v),    frame_err,        vecs[v].exp_ferr);
      check($sformatf("vec%0d busy after", v),   busy,             1'b0);
    end

    // False start: 12 clk low, then high
    base = valid_cnt;
    rx = 1'b0;
    repeat (12) @(negedge clk);
    rx = 1'b1;
    repeat (8) @(negedge clk);
    check("false start busy seen", busy, 1'b1);
    idle_bits(2);
    check("false start valid pulses", valid_cnt - base, 0);
    check("false start rx_data",      rx_data,   8'h7E);
    check("false start rx_status",    rx_status, 1'b1);
    check("false start busy after",   busy,      1'b0);

    // Framing error followed by a held-low line: no start until line returns high
    base = valid_cnt;
    send_frame(8'h3C, 1'b0);
    busy_cycles = 0;
    rx = 1'b0;
    for (int i = 0; i < 2 * BIT_CLK; i++) begin
      @(negedge clk);
      if (busy) busy_cycles = busy_cycles + 1;
    end
    check("break busy cycles",   busy_cycles,      0);
    check("ferr frame_err",      frame_err,        1'b1);
    check("ferr valid pulses",   valid_cnt - base, 0);
    check("ferr rx_data kept",   rx_data,          8'h7E);
    check("ferr rx_status",      rx_status,        1'b0);
    idle_bits(1);
    base = valid_cnt;
    send_frame(8'h81, 1'b1);
    idle_bits(2);
    check("after break valid pulses", valid_cnt - base, 1);
    check("after break rx_data",      rx_data,   8'h81);
    check("after break frame_err",    frame_err, 1'b0);

    // One-clk glitch in the middle of bit 3 of 0x00
    base = valid_cnt;
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b0);
    rx = 1'b0;
    repeat (32) @(negedge clk);
    rx = 1'b1;
    @(negedge clk);
    rx = 1'b0;
    repeat (BIT_CLK - 33) @(negedge clk);
    for (int i = 4; i < 8; i++) send_bit(1'b0);
    send_bit(1'b1);
    idle_bits(2);
    check("glitch valid pulses", valid_cnt - base, 1);
    check("glitch rx_data",      rx_data,   8'h00);
    check("glitch frame_err",    frame_err, 1'b0);

    // Back-to-back 0x00 then 0xFF with no idle gap
    base = valid_cnt;
    send_frame(8'h00, 1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    check("b2b first valid pulses", valid_cnt - base, 1);
    check("b2b first rx_data",      rx_data,   8'h00);
    check("b2b status at 2nd start", rx_status, 1'b0);
    for (int i = 1; i < 8; i++) send_bit(1'b1);
    send_bit(1'b1);
    idle_bits(2);
    check("b2b total valid pulses", valid_cnt - base, 2);
    check("b2b second rx_data",     rx_data,   8'hFF);
    check("b2b rx_status",          rx_status, 1'b1);

    // Reset during bit 4 of 0x55, line held low across release, then 0x12
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(((8'h55 >> i) & 8'h01) != 8'h00);
    rx = 1'b1;
    repeat (30) @(negedge clk);
    reset = 1'b0;
    rx    = 1'b0;
    repeat (3) @(negedge clk);
    check("midreset rx_data",   rx_data,   8'h00);
    check("midreset rx_valid",  rx_valid,  1'b0);
    check("midreset rx_status", rx_status, 1'b0);
    check("midreset frame_err", frame_err, 1'b0);
    check("midreset busy",      busy,      1'b0);
    repeat (7) @(negedge clk);
    reset = 1'b1;
    base = valid_cnt;
    busy_cycles = 0;
    for (int i = 0; i < BIT_CLK; i++) begin
      @(negedge clk);
      if (busy) busy_cycles = busy_cycles + 1;
    end
    check("post-reset low busy cycles", busy_cycles, 0);
    idle_bits(1);
    send_frame(8'h12, 1'b1);
    idle_bits(2);
    check("post-reset valid pulses", valid_cnt - base, 1);
    check("post-reset rx_data",      rx_data,   8'h12);
    check("post-reset rx_status",    rx_status, 1'b1);
    check("post-reset frame_err",    frame_err, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
